// File: rtl/mem_bus_arbiter.sv
// Two-master (CPU/DMA) arbiter for the shared memory port: round-robin with a
// bounded DMA burst lock and a wait-state watchdog that aborts dead transfers.
module mem_bus_arbiter #(
  parameter int WAIT_LIMIT = 16,
  parameter int MAX_BURST  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        dma_req,
  input  logic        dma_write,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic        dma_lock,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        mem_sel,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_ack,
  output logic        dma_ack,
  output logic [31:0] rdata,
  output logic        bus_error,
  output logic [1:0]  grant,
  output logic        cpu_stall
);
  localparam int WW = $clog2(WAIT_LIMIT);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, XFER_CPU, XFER_DMA, DONE} state_t;

  state_t          state;
  logic [WW-1:0]   wait_cnt;
  logic [BW-1:0]   burst_cnt;
  logic            last_dma;
  logic            pick_dma;

  // DMA keeps the bus on a tie only while its locked burst budget lasts
  always_comb begin
    pick_dma = 1'b0;
    if (dma_req && !cpu_req)
      pick_dma = 1'b1;
    else if (dma_req && cpu_req)
      pick_dma = !last_dma || (dma_lock && (burst_cnt < BW'(MAX_BURST)));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      mem_sel   <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      rdata     <= '0;
      bus_error <= 1'b0;
      grant     <= 2'b00;
      wait_cnt  <= '0;
      burst_cnt <= '0;
      last_dma  <= 1'b1;
    end else begin
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      bus_error <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req || dma_req) begin
            mem_sel  <= 1'b1;
            wait_cnt <= '0;
            if (pick_dma) begin
              grant     <= 2'b10;
              mem_write <= dma_write;
              mem_addr  <= dma_addr;
              mem_wdata <= dma_wdata;
              last_dma  <= 1'b1;
              state     <= XFER_DMA;
              if (!dma_lock)
                burst_cnt <= '0;
              else if (burst_cnt < BW'(MAX_BURST))
                burst_cnt <= burst_cnt + 1'b1;
            end else begin
              grant     <= 2'b01;
              mem_write <= cpu_write;
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
              last_dma  <= 1'b0;
              burst_cnt <= '0;
              state     <= XFER_CPU;
            end
          end
        end
        XFER_CPU, XFER_DMA: begin
          // a ready strobe in the limit cycle still wins over the abort
          if (mem_ready || (wait_cnt == WW'(WAIT_LIMIT - 1))) begin
            mem_sel   <= 1'b0;
            grant     <= 2'b00;
            rdata     <= (mem_ready && !mem_write) ? mem_rdata : '0;
            bus_error <= !mem_ready;
            if (state == XFER_CPU) cpu_ack <= 1'b1;
            else                   dma_ack <= 1'b1;
            state <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign cpu_stall = cpu_req & ~cpu_ack;
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single external memory/AMBA-side port between two masters:
  - the multicycle CPU, via its MemRead/MemWrite/IorD path;
  - a DMA engine.
- Produces the CPU stall signal that drives the control FSM's bus-lock input.
- Round-robin between masters, with a bounded DMA burst lock.
- A wait-state watchdog prevents a dead slave from hanging the CPU.

Parameters:
- WAIT_LIMIT, 16, max cycles a granted transfer waits for mem_ready before abort (≥2).
- MAX_BURST, 4, max consecutive DMA grants under dma_lock while cpu_req is pending (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU transfer request; held until cpu_ack.
- cpu_write  in  1  1=write, 0=read.
- cpu_addr  in  32  CPU address.
- cpu_wdata  in  32  CPU write data.
- dma_req  in  1  DMA transfer request; held until dma_ack.
- dma_write  in  1  1=write, 0=read.
- dma_addr  in  32  DMA address.
- dma_wdata  in  32  DMA write data.
- dma_lock  in  1  DMA requests burst priority.
- mem_ready  in  1  slave completion strobe.
- mem_rdata  in  32  slave read data, valid with mem_ready.
- mem_sel  out  1  transfer active on memory port.
- mem_write  out  1  transfer direction.
- mem_addr  out  32  registered address.
- mem_wdata  out  32  registered write data.
- cpu_ack  out  1  one-cycle completion pulse to CPU.
- dma_ack  out  1  one-cycle completion pulse to DMA.
- rdata  out  32  registered read data, valid with ack.
- bus_error  out  1  pulses with ack when the transfer timed out.
- grant  out  2  {dma,cpu} one-hot current owner, 00 when idle.
- cpu_stall  out  1  freeze to CPU control FSM.

Behaviour:
- States:
  - IDLE;
  - XFER_CPU;
  - XFER_DMA;
  - DONE (one cycle; ack and result presented).
- Reset (async, reset_n=0): state IDLE.
  - All outputs 0: mem_sel, mem_write, mem_addr, mem_wdata, cpu_ack, dma_ack, rdata, bus_error, grant.
  - last_grant=DMA, so the CPU wins the first tie.
  - wait_cnt=0, burst_cnt=0.
  - Applies at any point, including mid-transfer: mem_sel drops immediately and no ack is issued.
- IDLE arbitration, evaluated on each rising edge:
  - Only requester → granted.
  - Both requesting → the master not in last_grant wins.
  - Override: if last_grant=DMA, dma_lock=1 and burst_cnt<MAX_BURST, DMA wins.
  - On grant, latch the winner's addr/wdata/write into mem_*, set mem_sel=1, grant bit set, wait_cnt=0. Next state is XFER_x.
- burst_cnt:
  - DMA grant with dma_lock=1 → +1, saturating at MAX_BURST.
  - DMA grant with dma_lock=0 → 0.
  - Any CPU grant → 0.
- XFER_x:
  - Outputs held stable.
  - mem_ready=1 → latch rdata=mem_rdata (writes: rdata=0), mem_sel=0, grant=00, state DONE with ack_x=1, bus_error=0.
  - Otherwise wait_cnt+1.
  - If wait_cnt reaches WAIT_LIMIT-1 with mem_ready=0 → abort: mem_sel=0, grant=00, rdata=0, state DONE with ack_x=1, bus_error=1.
  - mem_ready in the limit cycle itself counts as success.
- DONE:
  - ack_x and bus_error high for exactly this cycle, then cleared.
  - Next state IDLE.
  - The acked master is excluded from this arbitration cycle; requesters drop req on the ack edge.
- Latency:
  - Request seen on edge N → mem_sel high from N.
  - Zero-wait slave (mem_ready in first XFER cycle) → ack in cycle N+2.
  - Arbitration gap of 1 cycle (DONE) between back-to-back transfers.
- cpu_stall = cpu_req & ~cpu_ack (combinational):
  - high from CPU request until the ack cycle, including while DMA owns the bus;
  - low in the ack cycle so the control FSM advances on that edge.
- Simultaneous events:
  - A new request arriving in the same cycle as mem_ready of the other master is held until IDLE.
  - mem_ready asserted in IDLE/DONE is ignored.
- Never both acks or both grant bits high; mem_sel=1 iff grant≠00.

Test Plan:
- Reset mid-transfer: CPU read, mem_ready held 0, reset_n pulsed low in the XFER cycle → mem_sel, grant, cpu_ack go 0 asynchronously; after release the first tie goes to the CPU.
- Single CPU read: cpu_req=1, addr=0x100, mem_ready in first XFER cycle with mem_rdata=0xDEADBEEF → mem_addr=0x100; cpu_ack 2 cycles after request with rdata=0xDEADBEEF; cpu_stall high 2 cycles then low.
- Tie, alternating: both req continuously, dma_lock=0, zero-wait slave → grant order CPU, DMA, CPU, DMA; each master's ack every 6 cycles.
- DMA burst lock: DMA granted first, then cpu_req and dma_req both held with dma_lock=1, MAX_BURST=4 → 4 consecutive DMA acks, then a CPU grant; burst_cnt returns to 0.
- Timeout: CPU write, mem_ready never asserted, WAIT_LIMIT=16 → cpu_ack and bus_error pulse 16 cycles after entering XFER_CPU; rdata=0; mem_sel low afterwards.
- DMA write with wait states: mem_ready after 3 wait cycles, dma_wdata=0x12345678 → mem_wdata stable for all 4 XFER cycles; dma_ack=1, bus_error=0; cpu_stall stays 0 with cpu_req=0.
